// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA pushes into a byte FIFO, a frame FSM serialises at BAUD_DIV.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_F100,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  output logic        uart_tx
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic          hit, wr_data, wr_stat, wr_div;
  logic          push_req, push, pop, full, empty, busy, tick;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  state_e        state_q;
  logic [7:0]    shift_q;
  logic          par_q, tx_q;
  logic [15:0]   fdiv_q, baud_q;
  logic [2:0]    bit_q;
  logic [31:0]   status;
  logic          unused_wdata;

  assign hit      = (Bus_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_data  = Bus_wen && hit && (Bus_addr[3:0] == 4'h0);
  assign wr_stat  = Bus_wen && hit && (Bus_addr[3:0] == 4'h4);
  assign wr_div   = Bus_wen && hit && (Bus_addr[3:0] == 4'h8);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign pop      = !busy && !empty;
  assign push_req = wr_data;
  // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
  assign push     = push_req && (!full || pop);
  assign tick     = (baud_q == fdiv_q - 16'd1);
  assign uart_tx  = tx_q;
  assign unused_wdata = ^Bus_wdata[31:16];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_req && full && !pop)    ovf_d = 1'b1;
    else if (wr_stat && Bus_wdata[3]) ovf_d = 1'b0;
    if (wr_div) div_d = (Bus_wdata[15:0] < 16'd2) ? 16'd2 : Bus_wdata[15:0];
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push) mem_q[wr_ptr_q] <= Bus_wdata[7:0];
  end

  // tx_q is loaded with the level of the state being entered, so the line never glitches.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      par_q   <= 1'b0;
      fdiv_q  <= 16'd2;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      if (busy) baud_q <= tick ? 16'd0 : baud_q + 16'd1;
      case (state_q)
        S_IDLE: if (!empty) begin
          shift_q <= mem_q[rd_ptr_q];
          par_q   <= ^mem_q[rd_ptr_q];
          fdiv_q  <= div_q;
          baud_q  <= '0;
          tx_q    <= 1'b0;
          state_q <= S_START;
        end
        S_START: if (tick) begin
          bit_q   <= '0;
          tx_q    <= shift_q[0];
          state_q <= S_DATA;
        end
        S_DATA: if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_q    <= par_q;
            state_q <= S_PARITY;
`else
            tx_q    <= 1'b1;
            state_q <= S_STOP;
`endif
          end else begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= {1'b0, shift_q[7:1]};
            tx_q    <= shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (tick) begin
          tx_q    <= 1'b1;
          state_q <= S_STOP;
        end
`endif
        S_STOP: if (tick) begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    status        = '0;
    status[0]     = busy;
    status[1]     = full;
    status[2]     = empty;
    status[3]     = ovf_q;
    status[4]     = PAR_EN;
    status[15:8]  = 8'(cnt_q);
  end

  always_comb begin
    Bus_rdata = '0;
    if (hit) begin
      case (Bus_addr[3:0])
        4'h4:    Bus_rdata = status;
        4'h8:    Bus_rdata = {16'h0, div_q};
        default: Bus_rdata = '0;
      endcase
    end
  end
endmodule
